// File: rtl/dm_store_rmw.sv
// dm_store_rmw: M-stage store unit for a word-only data memory.
// Word stores write straight through; byte and halfword stores read the
// target word, merge the new lane(s) in, and write the full word back.
// Misaligned stores raise ades and are dropped without touching memory.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | waiting for a store; latches the request when it is accepted
//  RD    | read strobe issued for the target word
//  MG    | read data on mem_rdata; merge store lane(s) into data_q
//  WR    | full word written to memory; pipeline released
module dm_store_rmw #(
    parameter logic [5:0] OPC_SB = 6'd40,
    parameter logic [5:0] OPC_SH = 6'd41,
    parameter logic [5:0] OPC_SW = 6'd43
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [5:0]  opcodeM,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ades,
    output logic        done,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_wdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_MG   = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [5:0]  opc_q, opc_d;

    logic        is_sb, is_sh, is_sw, is_store;
    logic        misaligned;
    logic        accept;
    logic [31:0] merge_word;

    // Decode the incoming request; only meaningful while IDLE.
    always_comb begin
        is_sb      = req && (opcodeM == OPC_SB);
        is_sh      = req && (opcodeM == OPC_SH);
        is_sw      = req && (opcodeM == OPC_SW);
        is_store   = is_sb || is_sh || is_sw;
        misaligned = (is_sh && addr[0]) || (is_sw && (addr[1:0] != 2'b00));
        // Reset wins over a simultaneous request.
        accept     = (state_q == S_IDLE) && is_store && !misaligned && !reset;
    end

    // Splice the latched store data into the word read back from memory.
    always_comb begin
        merge_word = mem_rdata;
        if (opc_q == OPC_SB) begin
            case (addr_q[1:0])
                2'd0:    merge_word[7:0]   = data_q[7:0];
                2'd1:    merge_word[15:8]  = data_q[7:0];
                2'd2:    merge_word[23:16] = data_q[7:0];
                default: merge_word[31:24] = data_q[7:0];
            endcase
        end else if (opc_q == OPC_SH) begin
            if (addr_q[1]) begin
                merge_word[31:16] = data_q[15:0];
            end else begin
                merge_word[15:0]  = data_q[15:0];
            end
        end
    end

    // Datapath register next values: latch on accept, merge in MG.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        opc_d  = opc_q;
        if (accept) begin
            addr_d = addr;
            data_d = wdata;
            opc_d  = opcodeM;
        end else if (state_q == S_MG) begin
            data_d = merge_word;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = is_sw ? S_WR : S_RD;
                end
            end
            S_RD:    state_d = S_MG;
            S_MG:    state_d = S_WR;
            S_WR:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; reset suppresses strobes in the same cycle so an
    // interrupted write never commits.
    always_comb begin
        busy      = 1'b0;
        ades      = 1'b0;
        done      = 1'b0;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = data_q;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    busy = accept;
                    ades = is_store && misaligned;
                end
                S_RD: begin
                    busy   = 1'b1;
                    mem_rd = 1'b1;
                end
                S_MG: begin
                    busy = 1'b1;
                end
                S_WR: begin
                    mem_we = 1'b1;
                    done   = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            opc_q   <= opc_d;
        end
    end

endmodule
